// File: rtl/store_checker_pkg.sv
// Shared types for the store-sequence checker: FSM state and failure codes.
package store_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        PASS  = 2'b10,
        FAIL  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        MISMATCH = 2'b01,
        TIMEOUT  = 2'b10
    } fail_code_t;

endpackage

// File: rtl/store_checker_if.sv
// Snooped data-memory write port: the processor drives it, the checker observes it.
interface store_checker_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_write;
    logic [ADDR_W-1:0] data_adr;
    logic [DATA_W-1:0] write_data;

    modport master (output mem_write, output data_adr, output write_data);
    modport slave  (input  mem_write, input  data_adr, input  write_data);
endinterface

// File: rtl/store_exp_table.sv
// Expected (address, data) table: one synchronous write port, one combinational read port.
module store_exp_table #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [ADDR_W-1:0]        raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // Contents are deliberately not reset so a table survives a checker reset.
    always_ff @(posedge clk) begin
        if (we) begin
            addr_mem[widx] <= waddr;
            data_mem[widx] <= wdata;
        end
    end

    assign raddr = addr_mem[ridx];
    assign rdata = data_mem[ridx];
endmodule

// File: rtl/store_checker.sv
// Store-sequence checker: compares snooped stores against a programmed table.
// Define STORE_CHECKER_WATCHDOG_EN to build the watchdog and its timeout failure.
module store_checker
    import store_checker_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned IGN_ADDR = 96,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en,
    input  logic [$clog2(DEPTH)-1:0]   load_idx,
    input  logic [ADDR_W-1:0]          load_addr,
    input  logic [DATA_W-1:0]          load_data,
    input  logic [$clog2(DEPTH+1)-1:0] num_exp,
    input  logic                       start,
    store_checker_if.slave             bus,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [ADDR_W-1:0]          fail_addr,
    output logic [DATA_W-1:0]          fail_data,
    output logic [$clog2(DEPTH+1)-1:0] match_cnt
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned NW = $clog2(DEPTH+1);

    state_t            state_q, state_d;
    fail_code_t        code_q;
    logic [NW-1:0]     cnt_q, num_q, num_clamp;
    logic [ADDR_W-1:0] fa_q, exp_addr;
    logic [DATA_W-1:0] fd_q, exp_data;
    logic              st_chk, st_hit, last_hit;
    logic              mis, done, wd_expire, tmo;

    store_exp_table #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_table (
        .clk   (clk),
        .we    (load_en && (state_q != ARMED)),
        .widx  (load_idx),
        .waddr (load_addr),
        .wdata (load_data),
        .ridx  (cnt_q[IW-1:0]),
        .raddr (exp_addr),
        .rdata (exp_data)
    );

    assign num_clamp = (num_exp > NW'(DEPTH)) ? NW'(DEPTH) : num_exp;
    assign st_chk    = (state_q == ARMED) && bus.mem_write && (bus.data_adr != ADDR_W'(IGN_ADDR));
    assign st_hit    = (bus.data_adr == exp_addr) && (bus.write_data == exp_data);
    assign last_hit  = (cnt_q + NW'(1)) == num_q;
    assign mis       = st_chk && !st_hit;
    assign done      = st_chk && st_hit && last_hit;
    // Mismatch and completion both outrank an expiring watchdog on the same edge.
    assign tmo       = wd_expire && !mis && !done;

`ifdef STORE_CHECKER_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT+1);
    logic [WD_W-1:0] wd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 wd_q <= '0;
        else if (start)            wd_q <= '0;
        else if (state_q == ARMED) wd_q <= wd_q + WD_W'(1);
    end

    assign wd_expire = (state_q == ARMED) && (wd_q == WD_W'(TIMEOUT-1));
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start)     state_d = (num_clamp == '0) ? PASS : ARMED;
        else if (mis)  state_d = FAIL;
        else if (done) state_d = PASS;
        else if (tmo)  state_d = FAIL;
    end

    always_comb begin
        busy = (state_q == ARMED);
        pass = (state_q == PASS);
        fail = (state_q == FAIL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q  <= '0;
            cnt_q  <= '0;
            code_q <= store_checker_pkg::NONE;
            fa_q   <= '0;
            fd_q   <= '0;
        end else if (start) begin
            num_q  <= num_clamp;
            cnt_q  <= '0;
            code_q <= store_checker_pkg::NONE;
            fa_q   <= '0;
            fd_q   <= '0;
        end else begin
            if (st_chk && st_hit) cnt_q <= cnt_q + NW'(1);
            if (mis) begin
                code_q <= store_checker_pkg::MISMATCH;
                fa_q   <= bus.data_adr;
                fd_q   <= bus.write_data;
            end else if (tmo) begin
                code_q <= store_checker_pkg::TIMEOUT;
                fa_q   <= '0;
                fd_q   <= '0;
            end
        end
    end

    assign fail_code = code_q;
    assign fail_addr = fa_q;
    assign fail_data = fd_q;
    assign match_cnt = cnt_q;
endmodule

// File: doc/store_checker.md
# store_checker

Synthesizable store-sequence checker that watches the processor's data-memory write port and compares every store against a programmed table of expected (address, data) pairs. It generalises the single "write 7 to 0x64, ignore 0x60" pass/fail check into a parametrised, reusable monitor with configurable depth, widths, an ignored scratch address and an optional watchdog. It sits beside `top`, snooping `MemWrite`/`DataAdr`/`WriteData`, and reports sticky pass/fail status for FPGA self-test and simulation.

## Interface
- `DATA_W`, 32, store data width
- `ADDR_W`, 32, store address width
- `DEPTH`, 8, expected-table entries
- `IGN_ADDR`, 96, address whose stores are skipped (never compared)
- `TIMEOUT`, 1024, watchdog limit in cycles after `start`
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-high reset
- `load_en` in 1: write table entry `load_idx` this cycle
- `load_idx` in $clog2(DEPTH): table index
- `load_addr` in ADDR_W: expected address
- `load_data` in DATA_W: expected data
- `num_exp` in $clog2(DEPTH+1): entries to check; sampled on `start`
- `start` in 1: arm / re-arm the checker
- `mem_write` in 1: processor store strobe
- `data_adr` in ADDR_W: store address
- `write_data` in DATA_W: store data
- `busy` out 1: armed and checking
- `pass` out 1: sticky, all `num_exp` stores matched
- `fail` out 1: sticky, check failed
- `fail_code` out 2: 00 none, 01 mismatch, 10 timeout
- `fail_addr` out ADDR_W: offending store address
- `fail_data` out DATA_W: offending store data
- `match_cnt` out $clog2(DEPTH+1): stores matched so far

## Operation
- States: IDLE, ARMED, PASS, FAIL. Reset → IDLE. All outputs are 0 in reset, including `busy`, `pass`, `fail`, `fail_code`, `fail_addr`, `fail_data` and `match_cnt`. The table contents are not reset.
- `load_en` is honoured only in IDLE, PASS or FAIL. It is ignored in ARMED.
- `start` in any state:
  - latch `num_exp`;
  - clear `match_cnt`, the fail fields and the watchdog;
  - go to ARMED, or to PASS if `num_exp`==0.
- In ARMED, on each edge with `mem_write`=1:
  - `data_adr`==IGN_ADDR: no action.
  - Otherwise the store is compared against table entry `match_cnt`, requiring both address and data to be equal.
  - On a match, `match_cnt`+1. If the new count equals the latched `num_exp`, go to PASS.
  - On a mismatch, go to FAIL with `fail_code`=01 and capture `data_adr`/`write_data`.
- Stores in IDLE/PASS/FAIL are ignored. Any store after PASS does not change status.
- `start` together with `mem_write` in the same cycle: `start` wins and that store is not checked.
- `num_exp` > DEPTH is clamped to DEPTH.

## Timing
- Status is registered. `pass`, `fail`, `match_cnt` and `fail_*` update on the same rising edge that samples the store, and are visible the following cycle.
- `busy`=1 from the edge after `start` until the edge entering PASS or FAIL.
- The watchdog counts cycles in ARMED. At the TIMEOUT-th cycle with no completion it enters FAIL with `fail_code`=10 and zeroed `fail_addr`/`fail_data`.
- A mismatch on the same edge as the timeout reports 01.
- `reset` mid-run clears all state asynchronously, without waiting for an edge.

## Configuration
- `STORE_CHECKER_WATCHDOG_EN`, defined: the watchdog counter and timeout failure exist.
- Undefined: no counter is built, `fail_code` 10 never occurs, and the checker stays ARMED indefinitely until a match or mismatch completes it.

## Structure
- `store_checker_pkg` holds:
  - the `state_t` enum (IDLE, ARMED, PASS, FAIL);
  - the `fail_code_t` enum (NONE=2'b00, MISMATCH=2'b01, TIMEOUT=2'b10).
- Sub-module `store_exp_table`: DEPTH×(ADDR_W+DATA_W) register file with one synchronous write port and one combinational read port indexed by `match_cnt`.

## Test plan
1. Load entry0={100,7}, `num_exp`=1, start. Stores (96,5), (96,9), (100,7) → `pass`=1 the cycle after the third store, `match_cnt`=1, `fail`=0.
2. Same setup, store (100,8) → `fail`=1, `fail_code`=01, `fail_addr`=100, `fail_data`=8, `busy`=0.
3. Same setup, store (64,7) → `fail`=1, `fail_code`=01, `fail_addr`=64.
4. TIMEOUT=16, start, no stores:
   - macro defined: `fail_code`=10 after 16 cycles;
   - macro undefined: `busy` still 1 at cycle 100.
5. Entries {0x10,1}, {0x14,2}, {0x18,3}, `num_exp`=3. Assert `reset` asynchronously after the first match → all outputs are 0 immediately. Then re-start and replay all three stores → pass.
6. `num_exp`=0 with start → `pass`=1 next cycle. Start during ARMED with 1 match → `match_cnt`=0. A store coincident with `start` is not counted.
